// File: rtl/fetch_if_id_stage.sv
// Fetch stage and IF/ID pipeline register for the 16-bit Thumb pipeline.
// Issues the fetch PC to a synchronous instruction memory (1-cycle read
// latency) and delivers instruction/PC/valid to decode. A single skid entry
// catches the fetch that is in flight when decode freezes, so every fetched
// instruction reaches decode exactly once. A taken branch from EXE flushes
// everything and redirects.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   FILL   | after reset or flush; no fetched data in flight yet
//   STREAM | fetches flowing, IF/ID loaded from memory each cycle
//   HOLD   | stalled with the in-flight instruction parked in the skid
module fetch_if_id_stage #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  PC_STEP     = 2,
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_pipeline_i,
  input  logic                   branch_taken_EXE_i,
  input  logic [PC_WIDTH-1:0]    branch_target_EXE_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  output logic                   imem_en_o,
  output logic [INSTR_WIDTH-1:0] instr_DECODE_o,
  output logic [PC_WIDTH-1:0]    pc_DECODE_o,
  output logic                   valid_DECODE_o,
  output logic [CNT_WIDTH-1:0]   stall_cycles_o
);

  localparam logic STALL_PIPELINE = 1'b1;

  typedef enum logic [1:0] {FILL, STREAM, HOLD} state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic                   resp_valid;
  logic [PC_WIDTH-1:0]    resp_pc;
  logic                   hold_valid;
  logic [INSTR_WIDTH-1:0] hold_instr;
  logic [PC_WIDTH-1:0]    hold_pc;
  logic                   stall;

  assign stall = (stall_pipeline_i == STALL_PIPELINE);

  // A fetch is issued only in an advancing cycle; the address is always fetch_pc.
  assign imem_addr_o = fetch_pc;
  assign imem_en_o   = !rst_i && !branch_taken_EXE_i && !stall;

  // Fetch sequencing, skid capture and IF/ID register; priority reset > branch > stall > advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= FILL;
      fetch_pc       <= RESET_PC;
      resp_valid     <= 1'b0;
      resp_pc        <= '0;
      hold_valid     <= 1'b0;
      hold_instr     <= '0;
      hold_pc        <= '0;
      instr_DECODE_o <= '0;
      pc_DECODE_o    <= '0;
      valid_DECODE_o <= 1'b0;
      stall_cycles_o <= '0;
    end else if (branch_taken_EXE_i) begin
      // Thumb targets are halfword aligned, so bit 0 is dropped.
      fetch_pc       <= branch_target_EXE_i & ~PC_WIDTH'(1);
      resp_valid     <= 1'b0;
      hold_valid     <= 1'b0;
      valid_DECODE_o <= 1'b0;
      state          <= FILL;
    end else if (stall) begin
      // Only the first stall cycle sees resp_valid; later ones keep the skid as is.
      if (resp_valid) begin
        hold_instr <= imem_rdata_i;
        hold_pc    <= resp_pc;
        hold_valid <= 1'b1;
        state      <= HOLD;
      end else begin
        state      <= state;
      end
      resp_valid <= 1'b0;
      if (stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(1);
    end else begin
      fetch_pc   <= fetch_pc + PC_WIDTH'(PC_STEP);
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
      state      <= STREAM;
      if (hold_valid) begin
        instr_DECODE_o <= hold_instr;
        pc_DECODE_o    <= hold_pc;
        valid_DECODE_o <= 1'b1;
        hold_valid     <= 1'b0;
      end else begin
        instr_DECODE_o <= imem_rdata_i;
        pc_DECODE_o    <= resp_pc;
        valid_DECODE_o <= resp_valid;
      end
    end
  end

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: directed vector table, a randomized run
// against a queue-based fetch model, and a second instance for PC wrap
// and stall-counter saturation.
module tb_fetch_if_id_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // ---------------- instance A: RESET_PC = 0, 16-bit counter ----------------
  logic        rst = 1'b1, stall = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0;
  logic [15:0] rdata = '0;
  logic [31:0] addr;
  logic        en;
  logic [15:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic [15:0] cnt;

  fetch_if_id_stage dut_a (
    .clk_i(clk), .rst_i(rst), .stall_pipeline_i(stall),
    .branch_taken_EXE_i(br), .branch_target_EXE_i(tgt),
    .imem_rdata_i(rdata), .imem_addr_o(addr), .imem_en_o(en),
    .instr_DECODE_o(instr), .pc_DECODE_o(pc), .valid_DECODE_o(valid),
    .stall_cycles_o(cnt)
  );

  // ---------------- instance B: wrap and 4-bit counter saturation ----------------
  logic        b_rst = 1'b1, b_stall = 1'b0;
  logic [15:0] b_rdata = '0;
  logic [31:0] b_addr;
  logic        b_en;
  logic [15:0] b_instr;
  logic [31:0] b_pc;
  logic        b_valid;
  logic [3:0]  b_cnt;

  fetch_if_id_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(4)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .stall_pipeline_i(b_stall),
    .branch_taken_EXE_i(1'b0), .branch_target_EXE_i(32'h0),
    .imem_rdata_i(b_rdata), .imem_addr_o(b_addr), .imem_en_o(b_en),
    .instr_DECODE_o(b_instr), .pc_DECODE_o(b_pc), .valid_DECODE_o(b_valid),
    .stall_cycles_o(b_cnt)
  );

  function automatic logic [15:0] instr_of(input logic [31:0] p);
    return 16'h1000 + p[16:1];
  endfunction

  // Synchronous instruction memories with 1-cycle latency.
  always @(posedge clk) begin
    if (en)   rdata   <= instr_of(addr);
    if (b_en) b_rdata <= instr_of(b_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: addresses issued but not yet delivered sit in a queue;
  // each advancing cycle delivers the oldest one and issues the next address.
  logic [31:0] m_next = '0;
  logic [31:0] m_q[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  int          m_stalls = 0;

  logic        pre_en;
  logic [31:0] pre_addr;

  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] t, input bit use_model);
    @(negedge clk);
    rst = r; stall = s; br = b; tgt = t;
    #1;
    pre_en   = en;
    pre_addr = addr;
    if (use_model) begin
      check("imem_en", {31'b0, pre_en}, {31'b0, (!r && !b && !s)});
      if (!r) check("imem_addr", pre_addr, m_next);
    end
    @(posedge clk);
    if (r) begin
      m_next = 32'h0; m_q.delete(); m_valid = 1'b0; m_stalls = 0;
    end else if (b) begin
      m_q.delete(); m_next = t & 32'hFFFF_FFFE; m_valid = 1'b0;
    end else if (s) begin
      m_stalls++;
    end else begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      m_q.push_back(m_next);
      m_next = m_next + 32'd2;
    end
    #1;
    if (use_model) begin
      check("valid", {31'b0, valid}, {31'b0, m_valid});
      if (m_valid) begin
        check("pc", pc, m_pc);
        check("instr", {16'b0, instr}, {16'b0, instr_of(m_pc)});
      end
      check("stall_cnt", {16'b0, cnt}, (m_stalls > 65535) ? 32'd65535 : m_stalls);
    end
  endtask

  task automatic step_b(input logic r, input logic s);
    @(negedge clk);
    b_rst = r; b_stall = s;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[23];

  initial begin
    //           rst  stl  br   tgt           en   addr          vld  pc            cnt
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        16'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        16'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        16'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h2,        1'b1,32'h0,        16'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h2,        16'd0};
    vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h6,        1'b1,32'h4,        16'd0};
    vecs[6]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h8,        1'b1,32'h4,        16'd1};
    vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b1,32'h6,        16'd1};
    vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hA,        1'b1,32'h8,        16'd1};
    vecs[9]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'hC,        1'b1,32'h8,        16'd2};
    vecs[10] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'hC,        1'b1,32'h8,        16'd3};
    vecs[11] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'hC,        1'b1,32'h8,        16'd4};
    vecs[12] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hC,        1'b1,32'hA,        16'd4};
    vecs[13] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hE,        1'b1,32'hC,        16'd4};
    vecs[14] = '{1'b0,1'b0,1'b1,32'h0000_0101,1'b0,32'h10,       1'b0,32'h0,        16'd4};
    vecs[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h100,      1'b0,32'h0,        16'd4};
    vecs[16] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h102,      1'b1,32'h100,      16'd4};
    vecs[17] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h104,      1'b1,32'h102,      16'd4};
    vecs[18] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h106,      1'b1,32'h102,      16'd5};
    vecs[19] = '{1'b0,1'b1,1'b1,32'h0000_0200,1'b0,32'h106,      1'b0,32'h0,        16'd5};
    vecs[20] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h200,      1'b0,32'h0,        16'd5};
    vecs[21] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h202,      1'b1,32'h200,      16'd5};
    vecs[22] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h204,      1'b1,32'h202,      16'd5};

    // Directed table: reset release, stalls, branch, branch+stall with held entry.
    for (int i = 0; i < 23; i++) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, 1'b0);
      check($sformatf("v%0d_en", i), {31'b0, pre_en}, {31'b0, vecs[i].en});
      if (i > 0) check($sformatf("v%0d_addr", i), pre_addr, vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
      if (vecs[i].valid) begin
        check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
        check($sformatf("v%0d_instr", i), {16'b0, instr}, {16'b0, instr_of(vecs[i].pc)});
      end
      check($sformatf("v%0d_cnt", i), {16'b0, cnt}, {16'b0, vecs[i].cnt});
    end

    // Randomized run against the reference model.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic r, s, b;
      r = ($urandom_range(0, 99) == 0);
      b = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) == 0);
      step(r, s, b, $urandom, 1'b1);
    end

    // Instance B: PC wrap past all-ones and counter saturation.
    step_b(1'b1, 1'b0);
    step_b(1'b1, 1'b0);
    check("b_reset_valid", {31'b0, b_valid}, 32'h0);
    check("b_reset_cnt", {28'b0, b_cnt}, 32'h0);
    step_b(1'b0, 1'b0);
    check("b_fill_valid", {31'b0, b_valid}, 32'h0);
    step_b(1'b0, 1'b0);
    check("b_pc0_valid", {31'b0, b_valid}, 32'h1);
    check("b_pc0", b_pc, 32'hFFFF_FFFC);
    step_b(1'b0, 1'b0);
    check("b_pc1", b_pc, 32'hFFFF_FFFE);
    check("b_instr1", {16'b0, b_instr}, {16'b0, instr_of(32'hFFFF_FFFE)});
    step_b(1'b0, 1'b0);
    check("b_pc_wrap", b_pc, 32'h0000_0000);
    check("b_instr_wrap", {16'b0, b_instr}, {16'b0, instr_of(32'h0)});
    for (int i = 0; i < 14; i++) step_b(1'b0, 1'b1);
    check("b_cnt_14", {28'b0, b_cnt}, 32'd14);
    check("b_addr_frozen", b_addr, 32'h0000_0004);
    for (int i = 0; i < 6; i++) step_b(1'b0, 1'b1);
    check("b_cnt_sat", {28'b0, b_cnt}, 32'd15);
    check("b_pc_held", b_pc, 32'h0000_0000);
    step_b(1'b0, 1'b0);
    check("b_after_stall_pc", b_pc, 32'h0000_0002);
    check("b_after_stall_valid", {31'b0, b_valid}, 32'h1);
    check("b_cnt_stays_sat", {28'b0, b_cnt}, 32'd15);
    step_b(1'b0, 1'b0);
    check("b_next_pc", b_pc, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
